// File: rtl/dwc_pkg.sv
// Shared definitions for the dual-with-compare checker: comparator states,
// default parameter values and status register bit positions.
package dwc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CMP   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam int DWC_DATA_WIDTH  = 32;
    localparam int DWC_FIFO_DEPTH  = 4;
    localparam int DWC_TIMEOUT     = 1024;
    localparam int DWC_CNT_WIDTH   = 16;
    localparam int DWC_HALT_ON_ERR = 1;

    // Bit positions of the comparator flags in the slave's status register
    localparam int STAT_MISMATCH_BIT = 0;
    localparam int STAT_TIMEOUT_BIT  = 1;
    localparam int STAT_BUSY_BIT     = 2;

endpackage

// File: rtl/dwc_sync_fifo.sv
// Single-clock FIFO with registered pointers and a combinational head word.
// One extra pointer bit separates the full and empty conditions.
module dwc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/dwc_result_comparator.sv
// Pairs core A and core B result words in arrival order, compares each pair
// and keeps mismatch/timeout status plus a saturating mismatch counter.
module dwc_result_comparator
    import dwc_pkg::*;
#(
    parameter int DATA_WIDTH  = DWC_DATA_WIDTH,
    parameter int FIFO_DEPTH  = DWC_FIFO_DEPTH,
    parameter int TIMEOUT     = DWC_TIMEOUT,
    parameter int CNT_WIDTH   = DWC_CNT_WIDTH,
    parameter int HALT_ON_ERR = DWC_HALT_ON_ERR
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  a_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    input  logic                  err_clr,
    output logic                  cmp_valid,
    output logic                  cmp_match,
    output logic                  mismatch_sticky,
    output logic                  timeout_sticky,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt,
    output logic                  fault_irq,
    output logic                  busy
);

    localparam int FW     = $clog2(FIFO_DEPTH) + 1;
    localparam int WAIT_W = $clog2(TIMEOUT);

    state_t state;
    state_t state_next;

    logic                  a_push, b_push;
    logic                  a_pop, b_pop;
    logic [DATA_WIDTH-1:0] a_head, b_head;
    logic                  a_full, b_full;
    logic                  a_empty, b_empty;
    logic [FW-1:0]         a_count, b_count;
    logic                  a_more, b_more;

    logic [WAIT_W-1:0]     wait_cnt;
    logic                  timeout_evt;
    logic                  mismatch_evt;
    logic                  cmp_valid_q;
    logic                  match_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign a_ready = !ARESET && !a_full && (state != S_FAULT);
    assign b_ready = !ARESET && !b_full && (state != S_FAULT);
    assign a_push  = a_valid && a_ready;
    assign b_push  = b_valid && b_ready;

    dwc_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (a_push),
        .push_data (a_data),
        .pop       (a_pop),
        .head      (a_head),
        .full      (a_full),
        .empty     (a_empty),
        .count     (a_count)
    );

    dwc_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (b_push),
        .push_data (b_data),
        .pop       (b_pop),
        .head      (b_head),
        .full      (b_full),
        .empty     (b_empty),
        .count     (b_count)
    );

    // Whether a FIFO still holds a word after its head is popped this cycle
    assign a_more = !a_empty && (a_count != FW'(1));
    assign b_more = !b_empty && (b_count != FW'(1));

    always_comb begin
        state_next   = state;
        a_pop        = 1'b0;
        b_pop        = 1'b0;
        timeout_evt  = 1'b0;
        mismatch_evt = 1'b0;
        case (state)
            S_IDLE: begin
                if (!a_empty && !b_empty)     state_next = S_CMP;
                else if (!a_empty || !b_empty) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!a_empty && !b_empty) begin
                    state_next = S_CMP;
                end else if (a_empty && b_empty) begin
                    state_next = S_IDLE;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_evt = 1'b1;
                    a_pop       = !a_empty;
                    b_pop       = !b_empty;
                    if (HALT_ON_ERR != 0)   state_next = S_FAULT;
                    else if (a_more || b_more) state_next = S_WAIT;
                    else                    state_next = S_IDLE;
                end
            end
            S_CMP: begin
                a_pop        = 1'b1;
                b_pop        = 1'b1;
                mismatch_evt = !match_q;
                if (!match_q && (HALT_ON_ERR != 0)) state_next = S_FAULT;
                else if (a_more != b_more)          state_next = S_WAIT;
                else                                state_next = S_IDLE;
            end
            S_FAULT: begin
                if (err_clr) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Control registers: state, wait timer, compare strobe
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            cmp_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            cmp_valid_q <= (state_next == S_CMP);
            // Any fresh WAIT entry, including re-entry after a timeout, starts at 0
            if ((state == S_WAIT) && (state_next == S_WAIT) && !timeout_evt)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    // Heads are stable until the CMP pop, so the compare can be taken a cycle early
    always_ff @(posedge ACLK) begin
        match_q <= (a_head == b_head);
    end

    // Status registers: an error event in the err_clr cycle wins over the clear
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            mismatch_sticky <= 1'b0;
            timeout_sticky  <= 1'b0;
            mismatch_cnt    <= '0;
        end else begin
            mismatch_sticky <= mismatch_evt || (mismatch_sticky && !err_clr);
            timeout_sticky  <= timeout_evt  || (timeout_sticky  && !err_clr);
            if (err_clr)
                mismatch_cnt <= mismatch_evt ? CNT_WIDTH'(1) : '0;
            else if (mismatch_evt)
                mismatch_cnt <= sat_inc(mismatch_cnt);
        end
    end

    assign cmp_valid = cmp_valid_q;
    assign cmp_match = cmp_valid_q && match_q;
    assign fault_irq = mismatch_sticky || timeout_sticky;
    assign busy      = (state != S_IDLE) || !a_empty || !b_empty;

endmodule
